// File: rtl/fir_decim_sat.sv
// Round, saturate and decimate stage following the FIR28 filter.
// Discards samples while the upstream delay line fills after reset.
module fir_decim_sat #(
    parameter int IN_W   = 30,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 13,
    parameter int DECIM  = 2,
    parameter int WARMUP = 36
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  filter_out,
    input  logic                    clr,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    sat_flag,
    output logic [7:0]              sat_cnt
);

    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [WW-1:0] WLAST = WW'(WARMUP - 1);
    localparam logic [PW-1:0] PLAST = PW'(DECIM - 1);

    localparam logic signed [IN_W:0] RND  = (IN_W+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [IN_W:0] MAXV =
        {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV =
        {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] MAXO = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MINO = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {S_WARM, S_RUN} state_t;

    state_t              state;
    logic [WW-1:0]       wcnt;
    logic [PW-1:0]       phase;
    logic                accept;
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] r;
    logic                r_valid;
    logic                hi;
    logic                lo;
    logic                clip;

    assign accept = en && (state == S_RUN) && (phase == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WARM;
            wcnt  <= '0;
            phase <= '0;
        end else if (en) begin
            unique case (state)
                S_WARM: begin
                    if (wcnt == WLAST) begin
                        state <= S_RUN;
                        wcnt  <= '0;
                        phase <= '0;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                S_RUN: begin
                    if (phase == PLAST) phase <= '0;
                    else                phase <= phase + PW'(1);
                end
            endcase
        end
    end

    // One guard bit keeps the rounding add from wrapping.
    assign ext = {filter_out[IN_W-1], filter_out};
    assign sum = ext + RND;
    assign rnd = sum >>> SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r       <= '0;
        end else begin
            r_valid <= accept;
            if (accept) r <= rnd;
        end
    end

    assign hi   = (r > MAXV);
    assign lo   = (r < MINV);
    assign clip = r_valid && (hi || lo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= r_valid;
            if (r_valid) begin
                unique case (1'b1)
                    hi:      dout <= MAXO;
                    lo:      dout <= MINO;
                    default: dout <= r[OUT_W-1:0];
                endcase
            end
        end
    end

    // A clip coinciding with clr survives as the first counted clip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
            sat_cnt  <= 8'd0;
        end else if (clr) begin
            sat_flag <= clip;
            sat_cnt  <= {7'd0, clip};
        end else if (clip) begin
            sat_flag <= 1'b1;
            if (sat_cnt != 8'hFF) sat_cnt <= sat_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fir_decim_sat.sv
// Randomized bench for fir_decim_sat against a queue-based model
// of accept timing, rounding, clipping and saturation counting.
module tb_fir_decim_sat;

    localparam int IN_W   = 30;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 13;
    localparam int DECIM  = 2;
    localparam int WARMUP = 36;

    logic                    clk;
    logic                    rst_n;
    logic                    en;
    logic signed [IN_W-1:0]  filter_out;
    logic                    clr;
    logic signed [OUT_W-1:0] dout;
    logic                    dout_valid;
    logic                    sat_flag;
    logic [7:0]              sat_cnt;

    fir_decim_sat #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT),
        .DECIM(DECIM), .WARMUP(WARMUP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .filter_out(filter_out), .clr(clr),
        .dout(dout), .dout_valid(dout_valid),
        .sat_flag(sat_flag), .sat_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int     due;
        longint val;
        bit     clip;
    } pend_t;

    pend_t  q[$];
    int     n_cmp;
    int     n_bad;
    int     ecnt;
    int     en_cnt;
    bit     exp_valid;
    bit     exp_flag;
    longint exp_dout;
    int     exp_cnt;

    function automatic longint rnd_sh(longint x);
        return (x + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    endfunction

    function automatic longint sat_v(longint v);
        longint mx = (longint'(1) <<< (OUT_W - 1)) - 1;
        longint mn = -(longint'(1) <<< (OUT_W - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic longint rand_x();
        logic signed [IN_W-1:0] t;
        if ($urandom_range(0, 3) == 0) begin
            t = IN_W'($urandom);
            return longint'(t);
        end
        return longint'($urandom_range(0, 2**28)) - 2**27;
    endfunction

    task automatic model_clear();
        q.delete();
        ecnt      = 0;
        en_cnt    = 0;
        exp_valid = 0;
        exp_flag  = 0;
        exp_dout  = 0;
        exp_cnt   = 0;
    endtask

    // Drive one edge and advance the model to what should be visible after it.
    task automatic tick(input bit e, input longint x, input bit c);
        bit     clip_now;
        longint rv;
        en         = e;
        filter_out = x[IN_W-1:0];
        clr        = c;
        @(posedge clk);
        ecnt++;
        exp_valid = 0;
        clip_now  = 0;
        if (q.size() > 0 && q[0].due == ecnt) begin
            pend_t p;
            p = q.pop_front();
            exp_valid = 1;
            exp_dout  = p.val;
            clip_now  = p.clip;
        end
        if (c) begin
            exp_flag = clip_now;
            exp_cnt  = clip_now ? 1 : 0;
        end else if (clip_now) begin
            exp_flag = 1;
            if (exp_cnt < 255) exp_cnt++;
        end
        if (e) begin
            en_cnt++;
            if (en_cnt > WARMUP && (en_cnt - WARMUP - 1) % DECIM == 0) begin
                pend_t p;
                rv     = rnd_sh(x);
                p.due  = ecnt + 1;
                p.val  = sat_v(rv);
                p.clip = (sat_v(rv) != rv);
                q.push_back(p);
            end
        end
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        model_clear();
        #2;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        filter_out = '0;
        assert_reset();
        n_cmp++;
        if (dout !== '0) begin
            n_bad++; $display("FAIL reset_dout: got %0d want 0", dout);
        end
        n_cmp++;
        if (dout_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b want 0", dout_valid);
        end
        n_cmp++;
        if (sat_flag !== 1'b0) begin
            n_bad++; $display("FAIL reset_flag: got %b want 0", sat_flag);
        end
        n_cmp++;
        if (sat_cnt !== 8'd0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d want 0", sat_cnt);
        end
        release_reset();
    endtask

    task automatic test_latency();
        int first = -1;
        for (int i = 0; i < 46; i++) begin
            tick(1'b1, rand_x() >>> 2, 1'b0);
            n_cmp++;
            if (dout_valid !== exp_valid) begin
                n_bad++;
                $display("FAIL lat_valid@%0d: got %b want %b",
                         ecnt, dout_valid, exp_valid);
            end
            n_cmp++;
            if (longint'(dout) !== exp_dout) begin
                n_bad++;
                $display("FAIL lat_dout@%0d: got %0d want %0d",
                         ecnt, dout, exp_dout);
            end
            if (dout_valid === 1'b1 && first < 0) first = ecnt;
        end
        n_cmp++;
        if (first !== WARMUP + 2) begin
            n_bad++;
            $display("FAIL first_valid: got %0d want %0d", first, WARMUP + 2);
        end
    endtask

    task automatic test_rounding();
        longint rv[4] = '{819200, 4096, -4096, 4095};
        longint re[4] = '{100, 1, 0, 0};
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4; k++) begin
                tick(1'b1, rv[v], 1'b0);
                if (exp_valid && k >= 1) begin
                    n_cmp++;
                    if (dout_valid !== 1'b1 || longint'(dout) !== re[v]) begin
                        n_bad++;
                        $display("FAIL round_%0d: got %0d/%b want %0d",
                                 rv[v], dout, dout_valid, re[v]);
                    end
                end
            end
        end
        n_cmp++;
        if (sat_flag !== 1'b0) begin
            n_bad++; $display("FAIL round_noflag: got %b want 0", sat_flag);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, rand_x(),
                 $urandom_range(0, 19) == 0);
            n_cmp++;
            if (dout_valid !== exp_valid || longint'(dout) !== exp_dout) begin
                n_bad++;
                $display("FAIL rand_out@%0d: got %b/%0d want %b/%0d",
                         ecnt, dout_valid, dout, exp_valid, exp_dout);
            end
            n_cmp++;
            if (sat_flag !== exp_flag || int'(sat_cnt) !== exp_cnt) begin
                n_bad++;
                $display("FAIL rand_sat@%0d: got %b/%0d want %b/%0d",
                         ecnt, sat_flag, sat_cnt, exp_flag, exp_cnt);
            end
        end
    endtask

    task automatic test_saturation();
        longint got[$];
        repeat (2) tick(1'b0, 0, 1'b0);
        tick(1'b0, 0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick(k < 4, (k < 2) ? 268435456 : -536870912, 1'b0);
            if (dout_valid === 1'b1) got.push_back(longint'(dout));
        end
        n_cmp++;
        if (got.size() != 2 || got[0] !== 32767 || got[1] !== -32768) begin
            n_bad++;
            $display("FAIL sat_vals: got n=%0d %0d %0d want 32767 -32768",
                     got.size(), got.size() > 0 ? got[0] : 0,
                     got.size() > 1 ? got[1] : 0);
        end
        n_cmp++;
        if (sat_flag !== 1'b1 || sat_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL sat_two: got %b/%0d want 1/2", sat_flag, sat_cnt);
        end
        repeat (600) tick(1'b1, 268435456, 1'b0);
        repeat (2) tick(1'b0, 0, 1'b0);
        n_cmp++;
        if (sat_cnt !== 8'd255 || int'(sat_cnt) !== exp_cnt) begin
            n_bad++;
            $display("FAIL sat_cap: got %0d want 255 (model %0d)",
                     sat_cnt, exp_cnt);
        end
    endtask

    task automatic test_clr();
        bit hit = 0;
        tick(1'b0, 0, 1'b1);
        n_cmp++;
        if (sat_flag !== 1'b0 || sat_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL clr_alone: got %b/%0d want 0/0", sat_flag, sat_cnt);
        end
        for (int i = 0; i < 8 && !hit; i++) begin
            hit = (q.size() > 0 && q[0].due == ecnt + 1);
            tick(1'b1, -536870912, hit);
        end
        n_cmp++;
        if (!hit || sat_flag !== 1'b1 || sat_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL clr_clip: got %b/%0d hit=%b want 1/1",
                     sat_flag, sat_cnt, hit);
        end
    endtask

    task automatic test_en_toggle();
        int first = -1;
        int vl[$];
        assert_reset();
        release_reset();
        for (int i = 0; i < 60; i++) begin
            tick(!(i >= 4 && i < 14), rand_x() >>> 2, 1'b0);
            if (dout_valid === 1'b1 && first < 0) first = ecnt;
        end
        n_cmp++;
        if (first !== WARMUP + 12) begin
            n_bad++;
            $display("FAIL warm_en_gap: got %0d want %0d", first, WARMUP + 12);
        end
        for (int i = 0; i < 40; i++) begin
            tick(i[0] == 1'b0, rand_x() >>> 2, 1'b0);
            n_cmp++;
            if (dout_valid !== exp_valid || longint'(dout) !== exp_dout) begin
                n_bad++;
                $display("FAIL tog_out@%0d: got %b/%0d want %b/%0d",
                         ecnt, dout_valid, dout, exp_valid, exp_dout);
            end
            if (dout_valid === 1'b1 && i > 4) vl.push_back(ecnt);
        end
        n_cmp++;
        if (vl.size() < 5 || vl[1] - vl[0] != 4 || vl[4] - vl[3] != 4) begin
            n_bad++;
            $display("FAIL tog_spacing: got n=%0d want spacing 4", vl.size());
        end
    endtask

    task automatic test_reset_midflight();
        int  first = -1;
        bit  armed = 0;
        for (int i = 0; i < 6 && !armed; i++) begin
            tick(1'b1, 819200, 1'b0);
            armed = (q.size() > 0);
        end
        assert_reset();
        n_cmp++;
        if (!armed || dout !== '0 || dout_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got %0d/%b armed=%b want 0/0",
                     dout, dout_valid, armed);
        end
        release_reset();
        for (int i = 0; i < 42; i++) begin
            tick(1'b1, 819200, 1'b0);
            if (dout_valid === 1'b1 && first < 0) first = ecnt;
        end
        n_cmp++;
        if (first !== WARMUP + 2 || longint'(dout) !== 100) begin
            n_bad++;
            $display("FAIL mid_rewarm: got edge %0d dout %0d want %0d/100",
                     first, dout, WARMUP + 2);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        filter_out = '0;
        test_reset();
        test_latency();
        test_rounding();
        test_random();
        test_saturation();
        test_clr();
        test_en_toggle();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
